// File: rtl/cpu_pkg.sv
// +-----------------------------------------------------------------------+
// | cpu_pkg: ALU opcodes, forward selects and datapath defaults            |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int AW_DEFAULT = 5;

  localparam logic [2:0] ALU_OR  = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // Opcodes are dense from ALU_OR up to ALU_MUL; everything above is unused.
  function automatic logic is_legal_alu(input logic [2:0] op);
    return (op <= ALU_MUL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/forward_unit.sv
// +-----------------------------------------------------------------------+
// | forward_unit: RAW bypass select for one source operand                |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module forward_unit #(
  parameter int DW = cpu_pkg::DW_DEFAULT,
  parameter int AW = cpu_pkg::AW_DEFAULT
) (
  input  logic          en,
  input  logic [AW-1:0] src,
  input  logic [DW-1:0] reg_data,
  input  logic          exmem_reg_write,
  input  logic [AW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_data,
  input  logic          memwb_reg_write,
  input  logic [AW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_data,
  output logic [1:0]    sel,
  output logic [DW-1:0] data
);
  import cpu_pkg::*;

  logic w_hit_exmem;
  logic w_hit_memwb;

  // x0 is hardwired zero, so a producer targeting it never bypasses.
  assign w_hit_exmem = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src);
  assign w_hit_memwb = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src);

  always_comb begin
    sel  = FWD_NONE;
    data = reg_data;
    if (en) begin
      if (w_hit_exmem) begin
        sel  = FWD_EXMEM;
        data = exmem_data;
      end else if (w_hit_memwb) begin
        sel  = FWD_MEMWB;
        data = memwb_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
// +-----------------------------------------------------------------------+
// | id_ex_operand_stage: ID/EX register with forwarding into the ALU      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module id_ex_operand_stage #(
  parameter int DW = cpu_pkg::DW_DEFAULT,
  parameter int AW = cpu_pkg::AW_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          valid_i,
  input  logic [DW-1:0] rs1_data_i,
  input  logic [DW-1:0] rs2_data_i,
  input  logic [DW-1:0] imm_i,
  input  logic [AW-1:0] rs1_addr_i,
  input  logic [AW-1:0] rs2_addr_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic          alu_src_i,
  input  logic [2:0]    alu_ctrl_i,
  input  logic          reg_write_i,
  input  logic          exmem_reg_write_i,
  input  logic [AW-1:0] exmem_rd_i,
  input  logic [DW-1:0] exmem_data_i,
  input  logic          memwb_reg_write_i,
  input  logic [AW-1:0] memwb_rd_i,
  input  logic [DW-1:0] memwb_data_i,
  output logic [DW-1:0] data1_o,
  output logic [DW-1:0] data2_o,
  output logic [2:0]    ALUCtrl_o,
  output logic [DW-1:0] store_data_o,
  output logic [AW-1:0] rd_addr_o,
  output logic          reg_write_o,
  output logic          valid_o,
  output logic          illegal_o,
  output logic [1:0]    fwd_a_o,
  output logic [1:0]    fwd_b_o
);
  import cpu_pkg::*;

  logic          r_valid;
  logic          r_reg_write;
  logic          r_illegal;
  logic [2:0]    r_alu_ctrl;
  logic          r_alu_src;
  logic [AW-1:0] r_rs1;
  logic [AW-1:0] r_rs2;
  logic [AW-1:0] r_rd;
  logic [DW-1:0] r_rs1_data;
  logic [DW-1:0] r_rs2_data;
  logic [DW-1:0] r_imm;

  logic          w_illegal;
  logic [DW-1:0] w_fwd_b_data;

  assign w_illegal = valid_i && !is_legal_alu(alu_ctrl_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_illegal   <= 1'b0;
      r_alu_ctrl  <= ALU_OR;
      r_alu_src   <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
    end else if (!stall_i) begin
      // An illegal opcode becomes a dead slot that only raises illegal_o.
      r_valid     <= valid_i && !w_illegal;
      r_reg_write <= reg_write_i && !w_illegal;
      r_illegal   <= w_illegal;
      r_alu_ctrl  <= w_illegal ? ALU_OR : alu_ctrl_i;
      r_alu_src   <= alu_src_i;
      r_rs1       <= rs1_addr_i;
      r_rs2       <= rs2_addr_i;
      r_rd        <= rd_addr_i;
      r_rs1_data  <= rs1_data_i;
      r_rs2_data  <= rs2_data_i;
      r_imm       <= imm_i;
    end
  end

  forward_unit #(.DW(DW), .AW(AW)) u_fwd_a (
    .en              (r_valid),
    .src             (r_rs1),
    .reg_data        (r_rs1_data),
    .exmem_reg_write (exmem_reg_write_i),
    .exmem_rd        (exmem_rd_i),
    .exmem_data      (exmem_data_i),
    .memwb_reg_write (memwb_reg_write_i),
    .memwb_rd        (memwb_rd_i),
    .memwb_data      (memwb_data_i),
    .sel             (fwd_a_o),
    .data            (data1_o)
  );

  forward_unit #(.DW(DW), .AW(AW)) u_fwd_b (
    .en              (r_valid),
    .src             (r_rs2),
    .reg_data        (r_rs2_data),
    .exmem_reg_write (exmem_reg_write_i),
    .exmem_rd        (exmem_rd_i),
    .exmem_data      (exmem_data_i),
    .memwb_reg_write (memwb_reg_write_i),
    .memwb_rd        (memwb_rd_i),
    .memwb_data      (memwb_data_i),
    .sel             (fwd_b_o),
    .data            (w_fwd_b_data)
  );

  assign data2_o      = r_alu_src ? r_imm : w_fwd_b_data;
  assign store_data_o = w_fwd_b_data;
  assign ALUCtrl_o    = r_alu_ctrl;
  assign rd_addr_o    = r_rd;
  assign reg_write_o  = r_reg_write && r_valid;
  assign valid_o      = r_valid;
  assign illegal_o    = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
// +-----------------------------------------------------------------------+
// | tb_id_ex_operand_stage: directed scoreboard bench for the ID/EX stage |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, valid;
  logic [31:0] rs1_data, rs2_data, imm;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        alu_src, reg_write;
  logic [2:0]  alu_ctrl;
  logic        exmem_rw, memwb_rw;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_data, memwb_data;

  logic [31:0] data1, data2, store_data;
  logic [2:0]  alu_ctrl_o;
  logic [4:0]  rd_addr_o;
  logic        reg_write_o, valid_o, illegal_o;
  logic [1:0]  fwd_a, fwd_b;

  typedef struct {
    string       tag;
    logic        v;
    logic        rw;
    logic        ill;
    logic [2:0]  ctrl;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] sd;
    logic [1:0]  fa;
    logic [1:0]  fb;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .stall_i           (stall),
    .flush_i           (flush),
    .valid_i           (valid),
    .rs1_data_i        (rs1_data),
    .rs2_data_i        (rs2_data),
    .imm_i             (imm),
    .rs1_addr_i        (rs1_addr),
    .rs2_addr_i        (rs2_addr),
    .rd_addr_i         (rd_addr),
    .alu_src_i         (alu_src),
    .alu_ctrl_i        (alu_ctrl),
    .reg_write_i       (reg_write),
    .exmem_reg_write_i (exmem_rw),
    .exmem_rd_i        (exmem_rd),
    .exmem_data_i      (exmem_data),
    .memwb_reg_write_i (memwb_rw),
    .memwb_rd_i        (memwb_rd),
    .memwb_data_i      (memwb_data),
    .data1_o           (data1),
    .data2_o           (data2),
    .ALUCtrl_o         (alu_ctrl_o),
    .store_data_o      (store_data),
    .rd_addr_o         (rd_addr_o),
    .reg_write_o       (reg_write_o),
    .valid_o           (valid_o),
    .illegal_o         (illegal_o),
    .fwd_a_o           (fwd_a),
    .fwd_b_o           (fwd_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic v, input logic rw, input logic ill,
                          input logic [2:0] ctrl, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] sd,
                          input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    e.tag = tag; e.v = v; e.rw = rw; e.ill = ill; e.ctrl = ctrl; e.rd = rd;
    e.d1 = d1; e.d2 = d2; e.sd = sd; e.fa = fa; e.fb = fb;
    sb.push_back(e);
  endtask

  // Pops the oldest expectation and compares every output against it.
  task automatic check_now();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".valid"},     {31'd0, valid_o},     {31'd0, e.v});
      chk({e.tag, ".reg_write"}, {31'd0, reg_write_o}, {31'd0, e.rw});
      chk({e.tag, ".illegal"},   {31'd0, illegal_o},   {31'd0, e.ill});
      chk({e.tag, ".alu_ctrl"},  {29'd0, alu_ctrl_o},  {29'd0, e.ctrl});
      chk({e.tag, ".rd"},        {27'd0, rd_addr_o},   {27'd0, e.rd});
      chk({e.tag, ".data1"},     data1,                e.d1);
      chk({e.tag, ".data2"},     data2,                e.d2);
      chk({e.tag, ".store"},     store_data,           e.sd);
      chk({e.tag, ".fwd_a"},     {30'd0, fwd_a},       {30'd0, e.fa});
      chk({e.tag, ".fwd_b"},     {30'd0, fwd_b},       {30'd0, e.fb});
    end
  endtask

  task automatic tick_check();
    @(posedge clk);
    #1;
    check_now();
  endtask

  task automatic load(input logic v, input logic [4:0] a1, input logic [31:0] d1,
                      input logic [4:0] a2, input logic [31:0] d2, input logic [31:0] im,
                      input logic src, input logic [2:0] op, input logic [4:0] rd, input logic rw);
    valid = v; rs1_addr = a1; rs1_data = d1; rs2_addr = a2; rs2_data = d2; imm = im;
    alu_src = src; alu_ctrl = op; rd_addr = rd; reg_write = rw;
  endtask

  task automatic fwd(input logic erw, input logic [4:0] erd, input logic [31:0] ed,
                     input logic mrw, input logic [4:0] mrd, input logic [31:0] md);
    exmem_rw = erw; exmem_rd = erd; exmem_data = ed;
    memwb_rw = mrw; memwb_rd = mrd; memwb_data = md;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    load(1'b1, 5'd3, 32'h77, 5'd4, 32'h88, 32'h0, 1'b0, 3'b011, 5'd3, 1'b1);
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    push_exp("reset", 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00);
    tick_check();

    rst = 1'b0;
    load(1'b1, 5'd5, 32'h10, 5'd6, 32'h3, 32'h0, 1'b0, 3'b011, 5'd9, 1'b1);
    push_exp("plain", 1, 1, 0, 3'b011, 5'd9, 32'h10, 32'h3, 32'h3, 2'b00, 2'b00);
    tick_check();

    load(1'b1, 5'd7, 32'h11, 5'd8, 32'h22, 32'h0, 1'b0, 3'b010, 5'd4, 1'b1);
    fwd(1'b1, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB);
    push_exp("fwd_both", 1, 1, 0, 3'b010, 5'd4, 32'hAA, 32'h22, 32'h22, 2'b10, 2'b00);
    tick_check();

    fwd(1'b0, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB);
    push_exp("fwd_memwb", 1, 1, 0, 3'b010, 5'd4, 32'hBB, 32'h22, 32'h22, 2'b01, 2'b00);
    tick_check();

    load(1'b1, 5'd0, 32'h33, 5'd8, 32'h22, 32'h0, 1'b0, 3'b001, 5'd4, 1'b1);
    fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
    push_exp("fwd_x0", 1, 1, 0, 3'b001, 5'd4, 32'h33, 32'h22, 32'h22, 2'b00, 2'b00);
    tick_check();

    load(1'b1, 5'd10, 32'h100, 5'd11, 32'h200, 32'h0, 1'b0, 3'b100, 5'd12, 1'b1);
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    push_exp("pre_stall", 1, 1, 0, 3'b100, 5'd12, 32'h100, 32'h200, 32'h200, 2'b00, 2'b00);
    tick_check();

    // Held instruction must follow its producer from EX/MEM into MEM/WB.
    stall = 1'b1;
    load(1'b1, 5'd1, 32'hDEAD, 5'd2, 32'hBEEF, 32'h1234, 1'b1, 3'b001, 5'd1, 1'b0);
    fwd(1'b1, 5'd11, 32'h5E, 1'b0, 5'd0, 32'h0);
    push_exp("stall1", 1, 1, 0, 3'b100, 5'd12, 32'h100, 32'h5E, 32'h5E, 2'b00, 2'b10);
    tick_check();

    fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'h6E);
    push_exp("stall2", 1, 1, 0, 3'b100, 5'd12, 32'h100, 32'h6E, 32'h6E, 2'b00, 2'b01);
    tick_check();

    fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'h7E);
    push_exp("stall3", 1, 1, 0, 3'b100, 5'd12, 32'h7E, 32'h200, 32'h200, 2'b01, 2'b00);
    tick_check();

    flush = 1'b1;
    push_exp("stall_flush", 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00);
    tick_check();

    stall = 1'b0; flush = 1'b0;
    load(1'b1, 5'd1, 32'h1, 5'd2, 32'h9, 32'hFFFF_FFFC, 1'b1, 3'b001, 5'd3, 1'b1);
    fwd(1'b1, 5'd2, 32'h55, 1'b0, 5'd0, 32'h0);
    push_exp("imm", 1, 1, 0, 3'b001, 5'd3, 32'h1, 32'hFFFF_FFFC, 32'h55, 2'b00, 2'b10);
    tick_check();

    load(1'b1, 5'd1, 32'h1, 5'd2, 32'h9, 32'h0, 1'b0, 3'b110, 5'd5, 1'b1);
    push_exp("illegal", 0, 0, 1, 3'b000, 5'd5, 32'h1, 32'h9, 32'h9, 2'b00, 2'b00);
    tick_check();

    load(1'b1, 5'd13, 32'hC0DE, 5'd14, 32'hF00D, 32'h0, 1'b0, 3'b000, 5'd15, 1'b1);
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    push_exp("legal_or", 1, 1, 0, 3'b000, 5'd15, 32'hC0DE, 32'hF00D, 32'hF00D, 2'b00, 2'b00);
    tick_check();

    rst = 1'b1; stall = 1'b1;
    push_exp("reset_over_stall", 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00);
    tick_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
